// File: rtl/div_sqrt_issue.sv
// Request-side controller for the shared div/sqrt unit: buffers requests, issues start
// pulses with held operands, captures the single-cycle done result and enforces a watchdog.
module div_sqrt_issue #(
  parameter int unsigned FIFO_DEPTH     = 2,
  parameter int unsigned TAG_W          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned C_RM           = 2   // matches fpu_defs_div_sqrt::C_RM
) (
  input  logic             Clk_CI,
  input  logic             Rst_RBI,
  input  logic             In_valid_SI,
  output logic             In_ready_SO,
  input  logic             Op_SI,
  input  logic [31:0]      Operand_a_DI,
  input  logic [31:0]      Operand_b_DI,
  input  logic [C_RM-1:0]  RM_SI,
  input  logic [TAG_W-1:0] Tag_DI,
  output logic             Div_start_SO,
  output logic             Sqrt_start_SO,
  output logic [31:0]      Operand_a_DO,
  output logic [31:0]      Operand_b_DO,
  output logic [C_RM-1:0]  RM_SO,
  input  logic             Unit_ready_SI,
  input  logic             Unit_done_SI,
  input  logic [31:0]      Unit_result_DI,
  input  logic             Unit_exp_OF_SI,
  input  logic             Unit_exp_UF_SI,
  input  logic             Unit_div_zero_SI,
  output logic             Out_valid_SO,
  input  logic             Out_ready_SI,
  output logic [31:0]      Result_DO,
  output logic [TAG_W-1:0] Tag_DO,
  output logic             Exp_OF_SO,
  output logic             Exp_UF_SO,
  output logic             Div_zero_SO,
  output logic             Timeout_SO,
  output logic             Busy_SO
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned WdW  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);
  localparam logic [WdW-1:0]  WdLast  = WdW'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0]     QNaN    = 32'h7FC0_0000;

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e state_q, state_d;

  logic [FIFO_DEPTH-1:0] fifo_op_q;
  logic [31:0]           fifo_a_q   [FIFO_DEPTH];
  logic [31:0]           fifo_b_q   [FIFO_DEPTH];
  logic [C_RM-1:0]       fifo_rm_q  [FIFO_DEPTH];
  logic [TAG_W-1:0]      fifo_tag_q [FIFO_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q, count_d;

  logic                  op_q;
  logic [31:0]           a_q, b_q;
  logic [C_RM-1:0]       rm_q;
  logic [TAG_W-1:0]      tag_q;
  logic [WdW-1:0]        wd_q, wd_d;

  logic                  out_valid_q, of_q, uf_q, dz_q, to_q;
  logic [31:0]           result_q;
  logic [TAG_W-1:0]      out_tag_q;

  logic push, pop, load_done, load_to;

  assign In_ready_SO = (count_q != CntFull);
  assign push        = In_valid_SI & In_ready_SO;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Payload storage needs no reset; validity is tracked by count_q alone.
  always_ff @(posedge Clk_CI) begin
    if (push) begin
      fifo_op_q[wr_ptr_q]  <= Op_SI;
      fifo_a_q[wr_ptr_q]   <= Operand_a_DI;
      fifo_b_q[wr_ptr_q]   <= Operand_b_DI;
      fifo_rm_q[wr_ptr_q]  <= RM_SI;
      fifo_tag_q[wr_ptr_q] <= Tag_DI;
    end
  end

  always_comb begin
    state_d   = state_q;
    wd_d      = wd_q;
    pop       = 1'b0;
    load_done = 1'b0;
    load_to   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if ((count_q != '0) && Unit_ready_SI && !out_valid_q) begin
          pop     = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        wd_d    = '0;
        state_d = StWait;
      end
      StWait: begin
        if (Unit_done_SI) begin
          load_done = 1'b1;
          state_d   = StIdle;
        end else if (wd_q == WdLast) begin
          load_to = 1'b1;
          state_d = StIdle;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wd_q     <= '0;
      op_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      rm_q     <= '0;
      tag_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wd_q    <= wd_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        op_q     <= fifo_op_q[rd_ptr_q];
        a_q      <= fifo_a_q[rd_ptr_q];
        b_q      <= fifo_b_q[rd_ptr_q];
        rm_q     <= fifo_rm_q[rd_ptr_q];
        tag_q    <= fifo_tag_q[rd_ptr_q];
      end
    end
  end

  // Loads only happen in WAIT, where out_valid_q is guaranteed low.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      out_tag_q   <= '0;
      of_q        <= 1'b0;
      uf_q        <= 1'b0;
      dz_q        <= 1'b0;
      to_q        <= 1'b0;
    end else begin
      if (out_valid_q && Out_ready_SI) out_valid_q <= 1'b0;
      if (load_done) begin
        out_valid_q <= 1'b1;
        result_q    <= Unit_result_DI;
        out_tag_q   <= tag_q;
        of_q        <= Unit_exp_OF_SI;
        uf_q        <= Unit_exp_UF_SI;
        dz_q        <= Unit_div_zero_SI;
        to_q        <= 1'b0;
      end else if (load_to) begin
        out_valid_q <= 1'b1;
        result_q    <= QNaN;
        out_tag_q   <= tag_q;
        of_q        <= 1'b0;
        uf_q        <= 1'b0;
        dz_q        <= 1'b0;
        to_q        <= 1'b1;
      end
    end
  end

  assign Div_start_SO  = (state_q == StIssue) & ~op_q;
  assign Sqrt_start_SO = (state_q == StIssue) & op_q;
  assign Operand_a_DO  = a_q;
  assign Operand_b_DO  = b_q;
  assign RM_SO         = rm_q;
  assign Out_valid_SO  = out_valid_q;
  assign Result_DO     = result_q;
  assign Tag_DO        = out_tag_q;
  assign Exp_OF_SO     = of_q;
  assign Exp_UF_SO     = uf_q;
  assign Div_zero_SO   = dz_q;
  assign Timeout_SO    = to_q;
  assign Busy_SO       = (count_q != '0) | (state_q != StIdle);

endmodule

// File: tb/tb_div_sqrt_issue.sv
// Directed bench for div_sqrt_issue with a simple fixed-latency unit model.
module tb_div_sqrt_issue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid, in_ready, op;
  logic [31:0] opa, opb;
  logic [1:0]  rm;
  logic [3:0]  tag;
  logic        div_start, sqrt_start;
  logic [31:0] oa, ob;
  logic [1:0]  rm_o;
  logic        unit_ready, unit_done;
  logic [31:0] unit_result;
  logic        u_of, u_uf, u_dz;
  logic        out_valid, out_ready;
  logic [31:0] result;
  logic [3:0]  tag_o;
  logic        of, uf, dz, to, busy;

  int total = 0;
  int bad   = 0;

  // Unit model state
  int          model_lat = 10;
  bit          model_never = 1'b0;
  logic [31:0] model_result = 32'h0;
  logic        model_done = 1'b0;
  logic        force_done = 1'b0;
  logic        m_of = 1'b0, m_uf = 1'b0, m_dz = 1'b0;
  int          rem = 0;

  int   div_cnt = 0, sqrt_cnt = 0, viol = 0;
  logic prev_start = 1'b0;
  logic [3:0] resp_q[$];

  always #5 clk = ~clk;

  div_sqrt_issue dut (
    .Clk_CI           (clk),
    .Rst_RBI          (rst_n),
    .In_valid_SI      (in_valid),
    .In_ready_SO      (in_ready),
    .Op_SI            (op),
    .Operand_a_DI     (opa),
    .Operand_b_DI     (opb),
    .RM_SI            (rm),
    .Tag_DI           (tag),
    .Div_start_SO     (div_start),
    .Sqrt_start_SO    (sqrt_start),
    .Operand_a_DO     (oa),
    .Operand_b_DO     (ob),
    .RM_SO            (rm_o),
    .Unit_ready_SI    (unit_ready),
    .Unit_done_SI     (unit_done),
    .Unit_result_DI   (unit_result),
    .Unit_exp_OF_SI   (u_of),
    .Unit_exp_UF_SI   (u_uf),
    .Unit_div_zero_SI (u_dz),
    .Out_valid_SO     (out_valid),
    .Out_ready_SI     (out_ready),
    .Result_DO        (result),
    .Tag_DO           (tag_o),
    .Exp_OF_SO        (of),
    .Exp_UF_SO        (uf),
    .Div_zero_SO      (dz),
    .Timeout_SO       (to),
    .Busy_SO          (busy)
  );

  assign unit_done   = model_done | force_done;
  assign unit_result = model_done ? model_result : 32'h0;
  assign u_of        = m_of;
  assign u_uf        = m_uf;
  assign u_dz        = m_dz;

  // Done fires model_lat cycles after the cycle holding the start pulse.
  always @(negedge clk) begin
    model_done = 1'b0;
    if (!rst_n) begin
      rem = 0;
    end else if ((div_start || sqrt_start) && !model_never) begin
      rem = model_lat;
    end else if (rem > 0) begin
      rem = rem - 1;
      if (rem == 0) model_done = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (div_start || sqrt_start) begin
      if (out_valid) viol++;
      if (prev_start) viol++;
      if (div_start && sqrt_start) viol++;
    end
    prev_start = div_start | sqrt_start;
    if (div_start) div_cnt++;
    if (sqrt_start) sqrt_cnt++;
    if (out_valid && out_ready) resp_q.push_back(tag_o);
  end

  // Called and returns on a negedge; the request is accepted at the posedge in between.
  task automatic push_req(input logic o, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] r, input logic [3:0] t);
    int n;
    in_valid = 1'b1; op = o; opa = a; opb = b; rm = r; tag = t;
    n = 0;
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int limit, output int n);
    n = 0;
    while (!out_valid && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_start(input int limit, output int n);
    n = 0;
    while (!(div_start || sqrt_start) && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if ({out_valid, div_start, sqrt_start, to, of, uf, dz} !== 7'b0) begin
      bad++; $display("FAIL rst_flags got=%b exp=0", {out_valid, div_start, sqrt_start, to, of, uf, dz});
    end
    total++; if ({result, oa, ob, tag_o, rm_o} !== 102'b0) begin
      bad++; $display("FAIL rst_data got=%h/%h/%h/%h/%h exp=0", result, oa, ob, tag_o, rm_o);
    end
  endtask

  task automatic test_div;
    int n;
    model_lat = 10; model_result = 32'h4040_0000;
    @(negedge clk);
    push_req(1'b0, 32'h40C0_0000, 32'h4000_0000, 2'b01, 4'd3);
    total++; if (div_start !== 1'b0) begin bad++; $display("FAIL div_start_c1 got=%b exp=0", div_start); end
    @(negedge clk);
    total++; if ({div_start, sqrt_start} !== 2'b10) begin
      bad++; $display("FAIL div_start_c2 got=%b exp=10", {div_start, sqrt_start});
    end
    total++; if ({oa, ob, rm_o} !== {32'h40C0_0000, 32'h4000_0000, 2'b01}) begin
      bad++; $display("FAIL div_operands got=%h %h %b exp=40c00000 40000000 01", oa, ob, rm_o);
    end
    wait_valid(100, n);
    total++; if (n !== 11) begin bad++; $display("FAIL div_latency got=%0d exp=11", n); end
    total++; if ({out_valid, result, tag_o} !== {1'b1, 32'h4040_0000, 4'd3}) begin
      bad++; $display("FAIL div_resp got=%b %h %0d exp=1 40400000 3", out_valid, result, tag_o);
    end
    total++; if ({of, uf, dz, to} !== 4'b0) begin
      bad++; $display("FAIL div_flags got=%b exp=0000", {of, uf, dz, to});
    end
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL div_consumed got=%b exp=0", out_valid); end
  endtask

  task automatic test_sqrt;
    int n, d0, s0;
    bit stable;
    model_lat = 10; model_result = 32'h4000_0000;
    d0 = div_cnt; s0 = sqrt_cnt;
    push_req(1'b1, 32'h4080_0000, 32'hDEAD_BEEF, 2'b11, 4'd5);
    wait_start(20, n);
    stable = 1'b1; n = 0;
    while (!out_valid && n < 100) begin
      if (oa !== 32'h4080_0000 || rm_o !== 2'b11) stable = 1'b0;
      @(negedge clk);
      n++;
    end
    total++; if (stable !== 1'b1) begin bad++; $display("FAIL sqrt_operand_stable got=0 exp=1"); end
    total++; if ({out_valid, result, tag_o} !== {1'b1, 32'h4000_0000, 4'd5}) begin
      bad++; $display("FAIL sqrt_resp got=%b %h %0d exp=1 40000000 5", out_valid, result, tag_o);
    end
    total++; if ((sqrt_cnt - s0) != 1 || (div_cnt - d0) != 0) begin
      bad++; $display("FAIL sqrt_pulses got=sqrt%0d div%0d exp=sqrt1 div0", sqrt_cnt - s0, div_cnt - d0);
    end
    @(negedge clk);
  endtask

  task automatic test_fifo_full;
    int n;
    model_lat = 30; model_result = 32'h3F80_0000;
    resp_q.delete();
    push_req(1'b0, 32'h3F80_0000, 32'h3F80_0000, 2'b00, 4'd7);
    wait_start(20, n);
    push_req(1'b0, 32'h4000_0000, 32'h3F80_0000, 2'b00, 4'd1);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL fifo_ready_1push got=%b exp=1", in_ready); end
    push_req(1'b0, 32'h4040_0000, 32'h3F80_0000, 2'b00, 4'd2);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fifo_ready_2push got=%b exp=0", in_ready); end
    push_req(1'b0, 32'h4080_0000, 32'h3F80_0000, 2'b00, 4'd3);
    n = 0;
    while (resp_q.size() < 4 && n < 600) begin
      @(negedge clk);
      n++;
    end
    total++; if (resp_q.size() != 4) begin bad++; $display("FAIL fifo_count got=%0d exp=4", resp_q.size()); end
    else begin
      total++; if ({resp_q[0], resp_q[1], resp_q[2], resp_q[3]} !== 16'h7123) begin
        bad++; $display("FAIL fifo_order got=%h exp=7123", {resp_q[0], resp_q[1], resp_q[2], resp_q[3]});
      end
    end
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL fifo_drained_busy got=%b exp=0", busy); end
  endtask

  task automatic test_backpressure;
    int n, d0;
    bit held;
    model_lat = 5; model_result = 32'h3F80_0000;
    out_ready = 1'b0;
    push_req(1'b0, 32'h4000_0000, 32'h4000_0000, 2'b00, 4'd4);
    push_req(1'b0, 32'h4120_0000, 32'h3F80_0000, 2'b00, 4'd5);
    wait_valid(100, n);
    model_result = 32'h4120_0000;
    d0 = div_cnt; held = 1'b1;
    repeat (20) begin
      if (out_valid !== 1'b1 || result !== 32'h3F80_0000 || tag_o !== 4'd4) held = 1'b0;
      @(negedge clk);
    end
    total++; if (held !== 1'b1) begin bad++; $display("FAIL bp_held got=0 exp=1"); end
    total++; if (div_cnt != d0) begin bad++; $display("FAIL bp_no_start got=%0d exp=%0d", div_cnt, d0); end
    out_ready = 1'b1;
    @(negedge clk);
    total++; if ({out_valid, div_start} !== 2'b00) begin
      bad++; $display("FAIL bp_h1 got=%b exp=00", {out_valid, div_start});
    end
    @(negedge clk);
    total++; if (div_start !== 1'b1) begin bad++; $display("FAIL bp_h2_start got=%b exp=1", div_start); end
    wait_valid(100, n);
    total++; if ({out_valid, result, tag_o} !== {1'b1, 32'h4120_0000, 4'd5}) begin
      bad++; $display("FAIL bp_second got=%b %h %0d exp=1 41200000 5", out_valid, result, tag_o);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout;
    int n;
    bit quiet;
    model_never = 1'b1; m_of = 1'b1; m_uf = 1'b1; m_dz = 1'b1;
    out_ready = 1'b0;
    push_req(1'b1, 32'h4080_0000, 32'h0, 2'b00, 4'd9);
    wait_start(20, n);
    wait_valid(200, n);
    total++; if (n !== 65) begin bad++; $display("FAIL to_latency got=%0d exp=65", n); end
    total++; if ({out_valid, result, tag_o, to} !== {1'b1, 32'h7FC0_0000, 4'd9, 1'b1}) begin
      bad++; $display("FAIL to_resp got=%b %h %0d to=%b exp=1 7fc00000 9 1", out_valid, result, tag_o, to);
    end
    total++; if ({of, uf, dz} !== 3'b0) begin bad++; $display("FAIL to_flags got=%b exp=000", {of, uf, dz}); end
    out_ready = 1'b1;
    @(negedge clk);
    force_done = 1'b1;
    @(negedge clk);
    force_done = 1'b0;
    quiet = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    total++; if (quiet !== 1'b1) begin bad++; $display("FAIL to_late_done got=response exp=none"); end
    model_never = 1'b0; m_of = 1'b0; m_uf = 1'b0; m_dz = 1'b0;
  endtask

  task automatic test_reset_wait;
    int n;
    bit seen;
    model_lat = 40; model_result = 32'h4040_0000;
    push_req(1'b0, 32'h40C0_0000, 32'h4000_0000, 2'b10, 4'd2);
    wait_start(20, n);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    test_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL rw_aborted got=response exp=none"); end
    model_lat = 10;
    push_req(1'b0, 32'h4110_0000, 32'h4040_0000, 2'b00, 4'd6);
    wait_valid(100, n);
    total++; if ({out_valid, result, tag_o, to} !== {1'b1, 32'h4040_0000, 4'd6, 1'b0}) begin
      bad++; $display("FAIL rw_new got=%b %h %0d to=%b exp=1 40400000 6 0", out_valid, result, tag_o, to);
    end
    @(negedge clk);
  endtask

  task automatic test_start_rules;
    total++; if (viol != 0) begin bad++; $display("FAIL start_rules got=%0d exp=0", viol); end
  endtask

  initial begin
    in_valid = 1'b0; op = 1'b0; opa = '0; opb = '0; rm = '0; tag = '0;
    unit_ready = 1'b1; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_div();
    test_sqrt();
    test_fifo_full();
    test_backpressure();
    test_timeout();
    test_reset_wait();
    test_start_rules();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
